// File: rtl/apb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_bridge_pkg
//   Shared types and defaults for the APB bridge blocks.
//   - APB_ADDR_W / APB_DATA_W : default APB address / data widths
//   - apb_state_e             : APB master transfer phases
// ----------------------------------------------------------------------------
package apb_bridge_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_fsm.sv
// ----------------------------------------------------------------------------
// apb_master_fsm
//   APB master that runs one transfer per grant from an upstream arbiter.
//   Writes win when both grants are high. Everything advances only on clk
//   edges where p_clk_en is high, so the APB side can run at a divided rate.
//
// Ports
//   clk, reset_n          : system clock, async active-low reset
//   p_clk_en              : APB clock enable
//   w_grant/w_addr/w_data/w_strb : granted write request
//   r_grant/r_addr        : granted read request
//   done                  : transfer completes this APB cycle (to arbiter)
//   w_resp_valid/r_resp_valid/resp_err/r_data : one-clk response
//   psel..pprot           : APB requester outputs
//   pready/pslverr/prdata : APB completer response
// ----------------------------------------------------------------------------
module apb_master_fsm
    import apb_bridge_pkg::*;
#(
    parameter int          ADDR_W    = APB_ADDR_W,
    parameter int          DATA_W    = APB_DATA_W,
    parameter logic [2:0]  PPROT_VAL = 3'b000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                p_clk_en,

    input  logic                w_grant,
    input  logic                r_grant,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic [ADDR_W-1:0]   r_addr,

    output logic                done,
    output logic                w_resp_valid,
    output logic                r_resp_valid,
    output logic                resp_err,
    output logic [DATA_W-1:0]   r_data,

    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,

    input  logic                pready,
    input  logic                pslverr,
    input  logic [DATA_W-1:0]   prdata
);

    apb_state_e state;

    // State and payload registers. The payload is captured only when leaving
    // S_IDLE, which keeps it stable across SETUP and all ACCESS wait states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (p_clk_en) begin
            case (state)
                S_IDLE: begin
                    if (w_grant) begin
                        state  <= S_SETUP;
                        pwrite <= 1'b1;
                        paddr  <= w_addr;
                        pwdata <= w_data;
                        pstrb  <= w_strb;
                    end else if (r_grant) begin
                        state  <= S_SETUP;
                        pwrite <= 1'b0;
                        paddr  <= r_addr;
                        pwdata <= '0;
                        pstrb  <= '0;
                    end
                end
                S_SETUP:  state <= S_ACCESS;
                // Going back to S_IDLE on completion guarantees an idle APB
                // cycle before the next SETUP, even with the grant still high.
                S_ACCESS: if (pready) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Control decoded straight from the state register so that reset drops
    // psel/penable at once, without waiting for an edge.
    assign psel    = (state != S_IDLE);
    assign penable = (state == S_ACCESS);
    assign pprot   = PPROT_VAL;

    // done is level-valid for the whole completing APB cycle; the response
    // pulses are qualified with p_clk_en so they are exactly one clk wide.
    assign done         = (state == S_ACCESS) & pready;
    assign w_resp_valid = done & p_clk_en & pwrite;
    assign r_resp_valid = done & p_clk_en & ~pwrite;
    assign resp_err     = pslverr;
    assign r_data       = prdata;

endmodule

// File: tb/tb_apb_master_fsm.sv
// ----------------------------------------------------------------------------
// tb_apb_master_fsm
//   Directed bench for apb_master_fsm. The driver pushes the expected response
//   of each transfer into a queue; a monitor pops and compares on every
//   response pulse. A small completer model inserts wait states on demand.
// ----------------------------------------------------------------------------
module tb_apb_master_fsm;

    localparam logic [2:0] PROT = 3'b101;

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p_clk_en;
    logic        w_grant, r_grant;
    logic [31:0] w_addr, w_data, r_addr;
    logic [3:0]  w_strb;
    logic        done, w_resp_valid, r_resp_valid, resp_err;
    logic [31:0] r_data;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int          vectors = 0;
    int          miscompares = 0;
    rsp_t        sb[$];

    // completer model controls
    int          wait_cycles = 0;
    int          acc_cnt = 0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    bit          throttle = 1'b0;
    logic [1:0]  en_cnt = 2'd0;

    always #5 clk = ~clk;

    apb_master_fsm #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .PPROT_VAL (PROT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .p_clk_en     (p_clk_en),
        .w_grant      (w_grant),
        .r_grant      (r_grant),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .w_strb       (w_strb),
        .r_addr       (r_addr),
        .done         (done),
        .w_resp_valid (w_resp_valid),
        .r_resp_valid (r_resp_valid),
        .resp_err     (resp_err),
        .r_data       (r_data),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pstrb        (pstrb),
        .pprot        (pprot),
        .pready       (pready),
        .pslverr      (pslverr),
        .prdata       (prdata)
    );

    // Enable is high every 4th clk when throttled.
    always @(posedge clk) en_cnt <= en_cnt + 2'd1;
    assign p_clk_en = throttle ? (en_cnt == 2'd3) : 1'b1;

    // Completer: holds pready low for wait_cycles enabled ACCESS cycles.
    always @(posedge clk) begin
        if (!reset_n)      acc_cnt <= 0;
        else if (p_clk_en) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
    end
    assign pready  = psel && penable && (acc_cnt >= wait_cycles);
    assign pslverr = rsp_err;
    assign prdata  = rsp_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected response.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (w_resp_valid || r_resp_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: w=%0b r=%0b but no response expected at %0t",
                         w_resp_valid, r_resp_valid, $time);
            end else begin
                e = sb.pop_front();
                chk("resp_w_valid", 32'(w_resp_valid), 32'(e.wr));
                chk("resp_r_valid", 32'(r_resp_valid), 32'(!e.wr));
                chk("resp_err", 32'(resp_err), 32'(e.err));
                if (!e.wr) chk("r_data", r_data, e.data);
            end
        end
    end

    // One transfer with p_clk_en always high. Cycle k counts negedges from the
    // one following the grant; setup_k/done_k report where SETUP and the
    // completing cycle fell.
    task automatic xfer(input bit wg, input bit rg,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] ra, input int waits, input bit err,
                        input logic [31:0] rd, output int setup_k, output int done_k);
        logic [31:0] ea;
        ea          = wg ? wa : ra;
        wait_cycles = waits;
        rsp_err     = err;
        rsp_data    = rd;
        sb.push_back('{wg, err, wg ? 32'h0 : rd});
        w_addr = wa; w_data = wd; w_strb = ws; r_addr = ra;
        w_grant = wg; r_grant = rg;
        setup_k = -1;
        done_k  = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (psel) chk("paddr_stable", paddr, ea);
            if (psel && !penable && setup_k < 0) begin
                setup_k = k;
                chk("setup_pwrite", 32'(pwrite), 32'(wg));
                chk("setup_pwdata", pwdata, wg ? wd : 32'h0);
                chk("setup_pstrb", 32'(pstrb), wg ? 32'(ws) : 32'h0);
            end
            if (done && p_clk_en) begin
                done_k = k;
                chk("done_penable", 32'(penable), 32'h1);
                break;
            end
        end
        if (done_k < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_timeout: no done within 100 cycles for addr 0x%08h", ea);
        end
        @(posedge clk); #1;
        w_grant = 1'b0;
        r_grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sk, dk, pulses;
        bit got;
        logic ps_q, pe_q, en_q;

        reset_n = 1'b0;
        w_grant = 1'b0; r_grant = 1'b0;
        w_addr = '0; w_data = '0; w_strb = '0; r_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_psel", 32'(psel), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_pwrite", 32'(pwrite), 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb", 32'(pstrb), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("pprot", 32'(pprot), 32'(PROT));

        // No grant after release: stays idle
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_grant", 32'(psel), 32'h0);
        @(posedge clk); #1;

        // Simple write, zero wait states
        xfer(1, 0, 32'h1000, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 32'h0, sk, dk);
        chk("wr_setup_cycle", 32'(sk), 32'd1);
        chk("wr_done_cycle", 32'(dk), 32'd2);

        // Read with 3 wait states and slave error
        xfer(0, 1, 32'h0, 32'h0, 4'h0, 32'h2004, 3, 1, 32'h12345678, sk, dk);
        chk("rd_setup_cycle", 32'(sk), 32'd1);
        chk("rd_done_cycle", 32'(dk), 32'd5);

        // Both grants: write goes first
        xfer(1, 1, 32'h0040, 32'h0BADF00D, 4'h5, 32'h0080, 0, 0, 32'hFFFF0000, sk, dk);
        chk("prio_done_cycle", 32'(dk), 32'd2);

        // Throttled APB clock: outputs move only on enabled edges
        throttle = 1'b1;
        wait_cycles = 0;
        rsp_err = 1'b0;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        w_addr = 32'h500; w_data = 32'hCAFEF00D; w_strb = 4'h3;
        w_grant = 1'b1;
        pulses = 0;
        got = 1'b0;
        @(negedge clk);
        ps_q = psel; pe_q = penable; en_q = p_clk_en;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!en_q) begin
                chk("thr_psel_frozen", 32'(psel), 32'(ps_q));
                chk("thr_penable_frozen", 32'(penable), 32'(pe_q));
            end
            if (w_resp_valid) pulses++;
            ps_q = psel; pe_q = penable; en_q = p_clk_en;
            if (done && p_clk_en && !got) begin
                got = 1'b1;
                @(posedge clk); #1;
                w_grant = 1'b0;
            end
        end
        chk("thr_resp_pulses", 32'(pulses), 32'd1);
        @(posedge clk); #1;
        throttle = 1'b0;

        // Back-to-back writes with the grant held high
        wait_cycles = 0;
        sb.push_back('{1'b1, 1'b0, 32'h0});
        sb.push_back('{1'b1, 1'b0, 32'h0});
        w_addr = 32'h10; w_data = 32'h11111111; w_strb = 4'hF;
        w_grant = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_psel_%0d", k), 32'(psel), (k == 0 || k == 3) ? 32'h0 : 32'h1);
            if (k == 1) chk("b2b_paddr0", paddr, 32'h10);
            if (k == 4) chk("b2b_paddr1", paddr, 32'h14);
            if (k == 2) begin
                @(posedge clk); #1;
                w_addr = 32'h14;
            end
        end
        @(posedge clk); #1;
        w_grant = 1'b0;
        @(negedge clk);
        chk("b2b_idle_after", 32'(psel), 32'h0);
        @(posedge clk); #1;

        // Reset in the middle of an ACCESS wait
        wait_cycles = 1000;
        r_addr = 32'h3000;
        r_grant = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (psel && penable) got = 1'b1;
        end
        chk("rstmid_reached_access", 32'(got), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_psel", 32'(psel), 32'h0);
        chk("rstmid_penable", 32'(penable), 32'h0);
        chk("rstmid_done", 32'(done), 32'h0);
        chk("rstmid_rvalid", 32'(r_resp_valid), 32'h0);
        r_grant = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Post-reset read completes normally
        xfer(0, 1, 32'h0, 32'h0, 4'h0, 32'h2008, 1, 0, 32'hA5A5C3C3, sk, dk);
        chk("post_rst_done_cycle", 32'(dk), 32'd3);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
